iob_bus_arbiter: RTL
====================

// Module: iob_bus_arbiter
// PURPOSE
//  Shares one IOb native slave port (internal RAM/boot memory) between the CPU instruction
//  bus (m0) and data bus (m1). Grants one requester at a time, muxes its request to the slave
//  and routes the response back to it. Round-robin or fixed priority; one transaction in flight.
// PARAMETERS
//  ADDR_W   32  address width of all ports
//  DATA_W   32  data width; wstrb width is DATA_W/8
//  RR        1  1: round-robin on contention; 0: fixed priority, m0 always wins
// PORTS
//  clk_i         in   1         clock
//  arst_n_i      in   1         asynchronous reset, active-low
//  cke_i         in   1         clock enable; when low all state holds
//  mN_avalid_i   in   1         request valid, N=0,1; held by master until mN_ready_o
//  mN_addr_i     in   ADDR_W    request address
//  mN_wdata_i    in   DATA_W    write data
//  mN_wstrb_i    in   DATA_W/8  byte strobes; 0 means read
//  mN_ready_o    out  1         request accepted (granted port only)
//  mN_rvalid_o   out  1         read data valid (granted port only)
//  mN_rdata_o    out  DATA_W    read data, = s_rdata_i broadcast to both masters
//  s_avalid_o    out  1         slave request valid
//  s_addr_o/s_wdata_o/s_wstrb_o  out  ADDR_W/DATA_W/DATA_W/8  muxed from grantee
//  s_ready_i     in   1         slave accepts request
//  s_rvalid_i    in   1         slave read data valid, >=1 cycle after acceptance
//  s_rdata_i     in   DATA_W    slave read data
// BEHAVIOUR
//  - States: IDLE, GRANT, WAIT_R. Regs: state, gnt (0/1), last (last served port).
//  - Reset: state=IDLE, gnt=0, last=1 (m0 wins first tie); s_avalid_o, all mN_ready_o,
//    mN_rvalid_o = 0; s_addr/wdata/wstrb = 0.
//  - Pick: one request -> that port; both -> RR ? ~last : 0.
//  - IDLE: any mN_avalid_i -> register pick into gnt, go GRANT. No request -> stay.
//    Latency: avalid rises in cycle t -> s_avalid_o high in t+1.
//  - GRANT: s_avalid_o = m[gnt]_avalid_i; s_addr/wdata/wstrb = m[gnt] fields, else 0;
//    m[gnt]_ready_o = s_ready_i & s_avalid_o, other ready = 0.
//    On accept (s_avalid_o & s_ready_i): last<=gnt; read (wstrb==0) -> WAIT_R;
//    write -> done; if the other port's avalid is high, gnt<=other, stay GRANT;
//    else IDLE. If m[gnt]_avalid_i drops without accept (protocol violation) -> IDLE.
//  - WAIT_R: s_avalid_o=0; on s_rvalid_i: m[gnt]_rvalid_o=1 same cycle (combinational);
//    then re-arbitrate over current requests (excluding none): pending -> GRANT with new
//    pick, else IDLE.
//  - Requesting master that issued a read may hold avalid for its next request; that
//    request competes normally in the completion-cycle pick.
//  - s_rvalid_i outside WAIT_R: ignored, never forwarded.
//  - Non-granted port: ready_o=0, rvalid_o=0 at all times; its request is never dropped,
//    only delayed. RR guarantees each port waits at most one other transaction.
//  - Reset asserted mid-transaction: immediate return to IDLE, all outputs to reset values;
//    an outstanding slave read response after reset release is ignored.
//  - cke_i low: state/gnt/last frozen; combinational outputs still follow inputs.
// STRUCTURE
//  - Header iob_bus_arbiter.vh: state encodings IDLE=2'd0, GRANT=2'd1, WAIT_R=2'd2,
//    port index constants M_INSTR=0, M_DATA=1.
//  - Sub-module iob_rr_pick2: combinational 2-way picker (req[1:0], last, RR -> pick).
//  - state/gnt/last held in iob_reg-style registers with arst_n_i and cke_i.
// TESTING
//  1 Reset: arst_n_i=0 with m0/m1 avalid=1 -> all ready/rvalid/s_avalid 0; release ->
//    s_avalid_o=1 next cycle with s_addr_o = m0_addr_i.
//  2 m1 read 0x100, slave ready same cycle, rvalid 2 cycles later rdata=0xDEADBEEF ->
//    m1_ready_o one pulse, m1_rvalid_o one pulse with 0xDEADBEEF, m0_rvalid_o stays 0.
//  3 Both avalid continuously, all writes, slave ready=1 -> grants alternate m0,m1,m0,...
//    one accept per cycle after first; with RR=0 -> m0 only while m0 requests.
//  4 m0 read pending in WAIT_R, m1 write arrives -> m1 not granted until m0 rvalid; m1
//    s_avalid_o in the rvalid cycle +1 (or same-cycle GRANT entry), wstrb=0xF passed.
//  5 Spurious s_rvalid_i in IDLE -> no mN_rvalid_o; slave ready held low 10 cycles ->
//    grantee waits, other port ready_o=0 throughout.
//  6 arst_n_i pulsed during WAIT_R -> IDLE; later s_rvalid_i ignored; next request
//    served normally.

Source files
------------

// File: rtl/iob_bus_arbiter_pkg.sv
// iob_bus_arbiter_pkg: shared state encoding and master port indices for the IOb arbiter.
package iob_bus_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        WAIT_R = 2'd2
    } state_t;
    localparam logic M_INSTR = 1'b0;
    localparam logic M_DATA  = 1'b1;
endpackage

// File: rtl/iob_bus_arbiter_pick2.sv
// iob_bus_arbiter_pick2: two-way picker, round-robin against the last served port or fixed m0 priority.
module iob_bus_arbiter_pick2 #(
    parameter bit RR = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick
);
    assign pick = (&req) ? (RR ? ~last : 1'b0) : req[1];
endmodule

// File: rtl/iob_bus_arbiter.sv
// iob_bus_arbiter: shares one IOb slave between the instruction (m0) and data (m1) masters,
// one transaction in flight, round-robin or fixed-priority arbitration.
module iob_bus_arbiter
    import iob_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR     = 1'b1
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                m0_avalid_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic                m0_ready_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_avalid_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic                m1_ready_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                s_avalid_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic                s_ready_i,
    input  logic                s_rvalid_i,
    input  logic [DATA_W-1:0]   s_rdata_i
);
    state_t     state, state_nxt;
    logic       gnt, gnt_nxt, last, last_nxt, pick, pick_last;
    logic [1:0] req;

    assign req        = {m1_avalid_i, m0_avalid_i};
    assign m0_rdata_o = s_rdata_i;
    assign m1_rdata_o = s_rdata_i;
    // while granted, gnt is about to become last, so the next pick rotates away from it
    assign pick_last  = (state == GRANT) ? gnt : last;

    iob_bus_arbiter_pick2 #(.RR(RR)) u_pick (
        .req  (req),
        .last (pick_last),
        .pick (pick)
    );

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        last_nxt    = last;
        s_avalid_o  = 1'b0;
        s_addr_o    = '0;
        s_wdata_o   = '0;
        s_wstrb_o   = '0;
        m0_ready_o  = 1'b0;
        m1_ready_o  = 1'b0;
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = (|req) ? GRANT : IDLE;
                gnt_nxt   = (|req) ? pick : gnt;
            end
            GRANT: begin
                s_avalid_o = req[gnt];
                s_addr_o   = s_avalid_o ? (gnt == M_DATA ? m1_addr_i : m0_addr_i) : '0;
                s_wdata_o  = s_avalid_o ? (gnt == M_DATA ? m1_wdata_i : m0_wdata_i) : '0;
                s_wstrb_o  = s_avalid_o ? (gnt == M_DATA ? m1_wstrb_i : m0_wstrb_i) : '0;
                m0_ready_o = gnt == M_INSTR && s_avalid_o && s_ready_i;
                m1_ready_o = gnt == M_DATA && s_avalid_o && s_ready_i;
                if (!s_avalid_o) begin
                    state_nxt = IDLE;
                end else if (s_ready_i) begin
                    last_nxt = gnt;
                    if (s_wstrb_o == '0) state_nxt = WAIT_R;
                    else if (req[~gnt]) gnt_nxt = pick;
                    else state_nxt = IDLE;
                end
            end
            WAIT_R: begin
                m0_rvalid_o = s_rvalid_i && gnt == M_INSTR;
                m1_rvalid_o = s_rvalid_i && gnt == M_DATA;
                if (s_rvalid_i) begin
                    state_nxt = (|req) ? GRANT : IDLE;
                    gnt_nxt   = (|req) ? pick : gnt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
            gnt   <= M_INSTR;
            last  <= M_DATA;
        end else if (cke_i) begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
        end
    end
endmodule
